// File: rtl/johnson_checker.sv
// Receive-side decoder and sequence checker for an N-bit Johnson counter stream.
// Decodes each sample, flags illegal or out-of-order codes, tracks lock and counts errors.
module johnson_checker #(
    parameter int N          = 4,
    parameter int LOCK_COUNT = 3,
    localparam int CW        = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_in,
    input  logic [N-1:0]  code_in,
    input  logic          err_clr,
    output logic          valid_out,
    output logic [CW-1:0] count_out,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked,
    output logic [7:0]    err_cnt
);

    localparam logic [1:0] SEARCH = 2'b00;
    localparam logic [1:0] VERIFY = 2'b01;
    localparam logic [1:0] LOCKED = 2'b10;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [CW:0] TWO_N      = (CW + 1)'(2 * N);

    // A Johnson word has at most one boundary between adjacent differing bits.
    function automatic logic is_legal(input logic [N-1:0] c);
        int unsigned edges;
        edges = 32'd0;
        for (int i = 0; i < N - 1; i++) begin
            if (c[i] != c[i+1]) begin
                edges = edges + 32'd1;
            end else begin
                edges = edges;
            end
        end
        return (edges <= 32'd1);
    endfunction

    function automatic logic [CW:0] popcount(input logic [N-1:0] c);
        logic [CW:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            p = p + {{CW{1'b0}}, c[i]};
        end
        return p;
    endfunction

    function automatic logic [CW-1:0] decode(input logic [N-1:0] c);
        logic [CW:0] p;
        logic [CW:0] d;
        p = popcount(c);
        if (c[N-1] || (c == '0)) begin
            d = p;
        end else begin
            d = TWO_N - p;
        end
        return d[CW-1:0];
    endfunction

    function automatic logic [N-1:0] successor(input logic [N-1:0] c);
        return {~c[0], c[N-1:1]};
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [N-1:0]  prev_r;
    logic [N-1:0]  prev_s;
    logic [3:0]    run_r;
    logic [3:0]    run_s;
    logic [3:0]    run_inc_s;
    logic          legal_s;
    logic          succ_s;
    logic [CW-1:0] idx_s;
    logic          ill_s;
    logic          seq_s;
    logic          flag_s;
    logic [7:0]    err_r;
    logic [7:0]    err_s;

    logic          valid_r;
    logic [CW-1:0] count_r;
    logic          ill_r;
    logic          seq_r;
    logic          locked_r;

    assign legal_s   = is_legal(code_in);
    assign succ_s    = (code_in == successor(prev_r));
    assign idx_s     = decode(code_in);
    assign run_inc_s = run_r + 4'd1;
    assign flag_s    = ill_s | seq_s;

    // Lock state machine, reference code and successor run tracking.
    always_comb begin
        state_s = state_r;
        prev_s  = prev_r;
        run_s   = run_r;
        ill_s   = 1'b0;
        seq_s   = 1'b0;
        if (valid_in) begin
            if (!legal_s) begin
                ill_s   = 1'b1;
                state_s = SEARCH;
                run_s   = 4'd0;
            end else begin
                prev_s = code_in;
                case (state_r)
                    SEARCH: begin
                        state_s = VERIFY;
                        run_s   = 4'd0;
                    end
                    VERIFY: begin
                        if (succ_s) begin
                            run_s = run_inc_s;
                            if (run_inc_s == LOCK_TARGET) begin
                                state_s = LOCKED;
                            end else begin
                                state_s = VERIFY;
                            end
                        end else begin
                            seq_s   = 1'b1;
                            run_s   = 4'd0;
                            state_s = VERIFY;
                        end
                    end
                    LOCKED: begin
                        if (succ_s) begin
                            state_s = LOCKED;
                        end else begin
                            seq_s   = 1'b1;
                            run_s   = 4'd0;
                            state_s = VERIFY;
                        end
                    end
                    default: begin
                        state_s = SEARCH;
                        run_s   = 4'd0;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
            prev_s  = prev_r;
            run_s   = run_r;
        end
    end

    // Saturating error counter; a clear coinciding with a flagged sample leaves one.
    always_comb begin
        err_s = err_r;
        if (err_clr) begin
            err_s = flag_s ? 8'd1 : 8'd0;
        end else if (flag_s && (err_r != 8'd255)) begin
            err_s = err_r + 8'd1;
        end else begin
            err_s = err_r;
        end
    end

    // State and registered outputs, all cleared by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r  <= SEARCH;
            prev_r   <= '0;
            run_r    <= 4'd0;
            err_r    <= 8'd0;
            valid_r  <= 1'b0;
            count_r  <= '0;
            ill_r    <= 1'b0;
            seq_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            prev_r   <= prev_s;
            run_r    <= run_s;
            err_r    <= err_s;
            valid_r  <= valid_in;
            count_r  <= (valid_in && legal_s) ? idx_s : '0;
            ill_r    <= ill_s;
            seq_r    <= seq_s;
            locked_r <= (state_s == LOCKED);
        end
    end

    assign valid_out = valid_r;
    assign count_out = count_r;
    assign illegal   = ill_r;
    assign seq_err   = seq_r;
    assign locked    = locked_r;
    assign err_cnt   = err_r;

endmodule

// File: tb/tb_johnson_checker.sv
// Self-checking bench for johnson_checker (N=4, LOCK_COUNT=3): index-table model
// compared every cycle, plus directed vectors with hand-computed expectations.
module tb_johnson_checker;

    localparam int NN   = 4;
    localparam int LOCK = 3;

    logic       clk;
    logic       rstn;
    logic       valid_in;
    logic [3:0] code_in;
    logic       err_clr;
    logic       valid_out;
    logic [2:0] count_out;
    logic       illegal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_cnt;

    int tests  = 0;
    int failed = 0;
    logic chk_en = 1'b0;

    // model state: mode 0 = no reference, 1 = verifying, 2 = locked
    int m_mode, m_prev, m_run, m_err;
    int e_valid, e_count, e_ill, e_seq, e_locked, e_err;

    johnson_checker #(.N(NN), .LOCK_COUNT(LOCK)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .code_in   (code_in),
        .err_clr   (err_clr),
        .valid_out (valid_out),
        .count_out (count_out),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Johnson code word for index k, straight from the index map
    function automatic int jcode(input int k);
        if (k <= NN) return ((1 << k) - 1) << (NN - k);
        else         return (1 << (2 * NN - k)) - 1;
    endfunction

    function automatic int index_of(input int c);
        for (int k = 0; k < 2 * NN; k++) begin
            if (jcode(k) == c) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic [3:0] c, input logic clr);
        int idx;
        int flag;
        if (!r) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_err = 0;
            e_valid = 0; e_count = 0; e_ill = 0; e_seq = 0;
        end else begin
            e_valid = v; e_count = 0; e_ill = 0; e_seq = 0;
            if (v) begin
                idx = index_of(int'(c));
                if (idx < 0) begin
                    e_ill = 1; m_mode = 0; m_run = 0;
                end else begin
                    e_count = idx;
                    if (m_mode == 0) begin
                        m_mode = 1; m_run = 0;
                    end else if ((m_prev + 1) % (2 * NN) == idx) begin
                        if (m_mode == 1) begin
                            m_run++;
                            if (m_run == LOCK) m_mode = 2;
                        end
                    end else begin
                        e_seq = 1; m_mode = 1; m_run = 0;
                    end
                    m_prev = idx;
                end
            end
            flag = (e_ill != 0 || e_seq != 0) ? 1 : 0;
            if (clr) m_err = flag;
            else if (flag != 0 && m_err < 255) m_err++;
        end
        e_locked = (m_mode == 2) ? 1 : 0;
        e_err    = m_err;
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] c, input logic clr);
        rstn = r; valid_in = v; code_in = c; err_clr = clr;
        @(posedge clk);
        model_update(r, v, c, clr);
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] c);
        step(1'b1, 1'b1, c, 1'b0);
    endtask

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_out", int'(valid_out), e_valid);
            chk("count_out", int'(count_out), e_count);
            chk("illegal",   int'(illegal),   e_ill);
            chk("seq_err",   int'(seq_err),   e_seq);
            chk("locked",    int'(locked),    e_locked);
            chk("err_cnt",   int'(err_cnt),   e_err);
        end
    end

    initial begin
        rstn = 1'b0; valid_in = 1'b0; code_in = 4'd0; err_clr = 1'b0;
        chk("model_idx_0111", index_of(7), 5);
        chk("model_idx_0001", index_of(1), 7);
        chk("model_idx_0110", index_of(6), -1);
        chk("model_code_3", jcode(3), 14);

        step(1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b1000, 1'b0);
        chk("reset_valid", int'(valid_out), 0);
        chk("reset_err", int'(err_cnt), 0);

        // lock acquisition
        drive(4'b0001); chk("acq_cnt0", int'(count_out), 7); chk("acq_lock0", int'(locked), 0);
        drive(4'b0000); chk("acq_cnt1", int'(count_out), 0);
        drive(4'b1000); chk("acq_cnt2", int'(count_out), 1); chk("acq_lock2", int'(locked), 0);
        drive(4'b1100); chk("acq_cnt3", int'(count_out), 2); chk("acq_lock3", int'(locked), 1);

        // illegal while locked, then a legal code from SEARCH
        drive(4'b0110);
        chk("ill_flag", int'(illegal), 1); chk("ill_cnt", int'(count_out), 0);
        chk("ill_err", int'(err_cnt), 1);  chk("ill_lock", int'(locked), 0);
        drive(4'b1110); chk("ill_noseq", int'(seq_err), 0); chk("ill_cnt2", int'(count_out), 3);
        drive(4'b1111); drive(4'b0111);
        drive(4'b0011); chk("relock", int'(locked), 1);
        drive(4'b0001); drive(4'b0000); drive(4'b1000); drive(4'b1100);

        // skipped state while locked at 1100
        drive(4'b1111);
        chk("skip_seq", int'(seq_err), 1); chk("skip_cnt", int'(count_out), 4);
        chk("skip_lock", int'(locked), 0); chk("skip_err", int'(err_cnt), 2);
        drive(4'b0111); chk("skip_c5", int'(count_out), 5);
        drive(4'b0011); chk("skip_c6", int'(count_out), 6); chk("skip_l6", int'(locked), 0);
        drive(4'b0001); chk("skip_c7", int'(count_out), 7); chk("skip_l7", int'(locked), 1);

        // walk the full cycle locked, then gap and wrap
        for (int k = 0; k < 7; k++) drive(4'(jcode(k)));
        drive(4'b0001); chk("gap_c7", int'(count_out), 7);
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 1'b0, 4'b0001, 1'b0);
            chk("gap_valid", int'(valid_out), 0);
        end
        drive(4'b0000);
        chk("wrap_c0", int'(count_out), 0); chk("wrap_lock", int'(locked), 1);
        chk("wrap_err", int'(err_cnt), 2);

        // error counter saturation and clear
        for (int i = 0; i < 300; i++) drive(4'b0110);
        chk("sat_err", int'(err_cnt), 255);
        step(1'b1, 1'b1, 4'b0101, 1'b1); chk("clr_flag_err", int'(err_cnt), 1);
        step(1'b1, 1'b0, 4'b0000, 1'b1); chk("clr_alone_err", int'(err_cnt), 0);

        // reset mid-lock with err_cnt = 5
        for (int i = 0; i < 5; i++) drive(4'b1010);
        drive(4'b1110); drive(4'b1111); drive(4'b0111); drive(4'b0011);
        chk("pre_rst_lock", int'(locked), 1); chk("pre_rst_err", int'(err_cnt), 5);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        chk("rst_valid", int'(valid_out), 0); chk("rst_lock", int'(locked), 0);
        chk("rst_err", int'(err_cnt), 0);     chk("rst_cnt", int'(count_out), 0);
        drive(4'b1000);
        chk("post_rst_seq", int'(seq_err), 0); chk("post_rst_cnt", int'(count_out), 1);
        drive(4'b1100); drive(4'b1110); drive(4'b1111);
        chk("post_rst_lock", int'(locked), 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/johnson_checker.md
# johnson_checker

Receive-side decoder and sequence checker for the team's N-bit Johnson counter stream. Samples a Johnson code word on each `valid_in`, decodes it to a binary state index, and flags illegal patterns and out-of-sequence steps. Runs a lock state machine that declares the stream locked after a run of correct successors, and keeps a saturating error count. Sits downstream of any Johnson counter whose bus crosses a block boundary and needs integrity monitoring.

## Interface
- `N`, 4: Johnson code width, N ≥ 2; the sequence has 2N states.
- `LOCK_COUNT`, 3: consecutive correct successors required to lock, 1..15.
- `CW` (derived, not overridable): $clog2(2N).
- `clk`, input, 1: clock; all logic runs on the rising edge.
- `rstn`, input, 1: reset, synchronous, active-low.
- `valid_in`, input, 1: `code_in` is sampled on this cycle.
- `code_in`, input, N: Johnson code word.
- `err_clr`, input, 1: synchronously clears `err_cnt`.
- `valid_out`, output, 1: result of the sample taken on the previous cycle.
- `count_out`, output, CW: decoded state index; 0 when the code is illegal.
- `illegal`, output, 1: the sampled code is not a Johnson pattern.
- `seq_err`, output, 1: the code is legal but is not the successor of the previous legal sample.
- `locked`, output, 1: the lock state machine is in LOCKED.
- `err_cnt`, output, 8: number of illegal plus seq_err events, saturates at 255.

## Operation
- Sequence direction: the successor of c is `{~c[0], c[N-1:1]}`. The MSB takes the inverted LSB and the word shifts right.
- Index map: index k, for 0 ≤ k ≤ N, has the top k bits set. Index k, for N < k < 2N, has the bottom 2N−k bits set.
  - N=4 example: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Legal code: at most one i in 0..N−2 with `code[i] != code[i+1]`. All other codes are illegal.
- Decode:
  - If MSB = 1 or code = 0: index = popcount.
  - Otherwise: index = 2N − popcount.
- Wrap-around: index 2N−1 to index 0 (0001 to 0000 for N=4) is a correct successor.
- A register `prev` holds the last legal sampled code. A counter `run` has 4 bits.
- States:
  - **SEARCH**: no reference code is held.
    - A legal sample loads `prev` and goes to VERIFY with run=0.
    - An illegal sample sets `illegal` and stays in SEARCH.
    - `seq_err` is never asserted in SEARCH.
  - **VERIFY**:
    - Correct successor: `run` increments and `prev` loads the sample. When `run` reaches LOCK_COUNT, go to LOCKED.
    - Legal non-successor: set `seq_err`, clear `run`, load `prev`, stay in VERIFY.
    - Illegal: set `illegal` and go to SEARCH.
  - **LOCKED**:
    - Correct successor: load `prev` and stay in LOCKED.
    - Legal non-successor: set `seq_err`, load `prev`, go to VERIFY with run=0.
    - Illegal: set `illegal` and go to SEARCH.
- `illegal` and `seq_err` are mutually exclusive per sample.
- A cycle with `valid_in` low changes no state, `prev`, `run` or `err_cnt`.
- `err_cnt`:
  - Increments by 1 per flagged sample.
  - Holds at 255.
  - When `err_clr` and a flagged sample occur in the same cycle, the result is 1. When `err_clr` occurs alone, the result is 0.

## Timing
- Latency is 1 cycle. A sample on edge t produces `valid_out`, `count_out`, `illegal` and `seq_err` registered after edge t. These hold for exactly one cycle; `valid_out` follows the `valid_in` pattern delayed by one cycle.
- When `valid_out` is low, `count_out`, `illegal` and `seq_err` are 0.
- `locked` and `err_cnt` update on the same edge as the `valid_out` of the triggering sample.
- Back-to-back samples on every cycle are supported with no bubbles.
- Reset (`rstn` low at an edge) forces the following after that edge, regardless of `valid_in`:
  - All outputs 0: `valid_out`, `count_out`, `illegal`, `seq_err`, `locked`, `err_cnt`.
  - Internal state: SEARCH, run=0, prev=0.
  - The same applies when reset arrives mid-lock.

## Test plan
All scenarios use N=4 and LOCK_COUNT=3.
- **Lock acquisition:** after reset, drive 0001, 0000, 1000, 1100 on consecutive cycles.
  - Required: `valid_out` sequence with `count_out` 7, 0, 1, 2.
  - Required: no errors, and `locked` rises together with the 4th `valid_out`.
- **Illegal code:** while locked, drive 0110.
  - Required: `illegal`=1, `count_out`=0, `err_cnt`=1, and `locked` low on the same cycle.
  - Then drive 1110. Required: no `seq_err`, state is VERIFY.
- **Skipped state:** while locked at 1100, drive 1111.
  - Required: `seq_err`=1, `count_out`=4, `locked`=0.
  - Then drive 0111, 0011, 0001. Required: `count_out` 5, 6, 7, and `locked` reasserts with the 0001 result.
- **Gaps and wrap:** while locked, drive 0001, then `valid_in` low for 5 cycles, then 0000.
  - Required: `valid_out` low during the gap, `count_out` 7 then 0, `locked` stays 1, no errors.
- **Error counter:**
  - 300 illegal samples: required `err_cnt`=255.
  - `err_clr` plus an illegal sample in the same cycle: required `err_cnt`=1.
  - `err_clr` alone: required `err_cnt`=0.
- **Reset mid-operation:** while locked with `err_cnt`=5, hold `rstn` low for one edge with `valid_in`=1.
  - Required: all outputs 0 on the next cycle.
  - Next legal sample: required no `seq_err`, because the block is back in SEARCH.
